// File: rtl/sel_pkg.sv
// Shared encodings for the keypad selection path: FSM states, code width,
// digit-key count and the digit priority helper.
package sel_pkg;

  localparam int CODE_W     = 2;
  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    S_LINHA    = 2'b00,
    S_COLUNA   = 2'b01,
    S_CONFIRMA = 2'b10,
    S_FIM      = 2'b11
  } state_t;

  // Lowest-index digit wins when several keys fire together.
  function automatic logic [CODE_W-1:0] first_digit(input logic [NUM_DIGITS-1:0] ev);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--)
      if (ev[i]) idx = CODE_W'(i);
    return idx;
  endfunction

endpackage

// File: rtl/seletor_codigo_debouncer.sv
// One key: 2-FF synchronizer, consecutive-cycle debouncer and a one-cycle
// pulse on each debounced press.
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic clr_n,
  input  logic raw,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          s1, s2, level, armed, flip;
  logic [CW-1:0] cnt;

  assign flip = (s2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

  // Sync stages come out of reset high so a key held through reset is never
  // armed; it must be seen released before its next press counts.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      level <= 1'b0;
      cnt   <= '0;
      armed <= 1'b0;
      rise  <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= flip && !level && armed;
      if (!level && !s2) armed <= 1'b1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (flip) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seletor_codigo.sv
// Keypad front-end: debounces digit/OK/CANCEL keys and sequences row, column
// and confirm strobes towards the code registers and dispense logic.
module seletor_codigo
  import sel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic [NUM_DIGITS-1:0] btn,
  input  logic                  btn_ok,
  input  logic                  btn_cancel,
  output logic [CODE_W-1:0]     code,
  output logic                  enL,
  output logic                  enC,
  output logic                  clr_sel,
  output logic                  sel_valid,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  localparam int NUM_KEYS = NUM_DIGITS + 2;
  localparam int TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [NUM_KEYS-1:0] keys, ev;
  logic                ev_ok, ev_cancel, dig_any, timeout;
  logic [CODE_W-1:0]   dig_code, code_nx;
  logic                load_row, load_col, clear_nx, valid_nx;
  logic [TW-1:0]       timer;
  state_t              state, state_nx;

  assign keys = {btn_cancel, btn_ok, btn};

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [NUM_KEYS-1:0] (
    .clk  (clk),
    .clr_n(clr_n),
    .raw  (keys),
    .rise (ev)
  );

  assign ev_ok     = ev[NUM_DIGITS];
  assign ev_cancel = ev[NUM_DIGITS+1];
  assign dig_any   = |ev[NUM_DIGITS-1:0];
  assign dig_code  = first_digit(ev[NUM_DIGITS-1:0]);
  assign timeout   = (state == S_COLUNA || state == S_CONFIRMA) &&
                     (timer == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nx = state;
    code_nx  = code;
    load_row = 1'b0;
    load_col = 1'b0;
    clear_nx = 1'b0;
    valid_nx = 1'b0;
    unique case (state)
      S_LINHA: begin
        if (ev_cancel) begin
          clear_nx = 1'b1;
        end else if (dig_any) begin
          code_nx  = dig_code;
          load_row = 1'b1;
          state_nx = S_COLUNA;
        end
      end
      S_COLUNA: begin
        if (ev_cancel || timeout) begin
          clear_nx = 1'b1;
          state_nx = S_LINHA;
        end else if (dig_any) begin
          code_nx  = dig_code;
          load_col = 1'b1;
          state_nx = S_CONFIRMA;
        end
      end
      S_CONFIRMA: begin
        if (ev_cancel || timeout) begin
          clear_nx = 1'b1;
          state_nx = S_LINHA;
        end else if (ev_ok) begin
          valid_nx = 1'b1;
          state_nx = S_FIM;
        end else if (dig_any) begin
          code_nx  = dig_code;
          load_col = 1'b1;
        end
      end
      S_FIM: state_nx = S_LINHA;
      default: state_nx = S_LINHA;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= S_LINHA;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      code      <= '0;
      enL       <= 1'b0;
      enC       <= 1'b0;
      clr_sel   <= 1'b0;
      sel_valid <= 1'b0;
    end else begin
      code      <= code_nx;
      enL       <= load_row;
      enC       <= load_col;
      clr_sel   <= clear_nx;
      sel_valid <= valid_nx;
    end
  end

  // Every accepted event (which always yields a strobe) restarts the idle timer.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)
      timer <= '0;
    else if (load_row || load_col || clear_nx || valid_nx)
      timer <= '0;
    else if (timer != TW'(TIMEOUT_CYCLES - 1))
      timer <= timer + 1'b1;
  end

  assign busy      = (state != S_LINHA);
  assign state_dbg = state;

endmodule

// File: doc/seletor_codigo.md
Name: seletor_codigo

Overview:
Keypad front-end for the vending machine selection path, directly upstream of the row/column code registers. It synchronizes and debounces four digit keys plus OK and CANCEL keys. A selection FSM then issues the 2-bit code with one-cycle row-load (enL) and column-load (enC) strobes, a clear strobe for the registers, and a final sel_valid strobe once the customer confirms.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive synchronized cycles a raw key level must hold before the debounced level changes (bench uses 4).
TIMEOUT_CYCLES, 1000, idle cycles allowed in S_COLUNA/S_CONFIRMA before the selection is abandoned (bench uses 20).

Ports:
clk  in  1  system clock, all logic rising-edge
clr_n  in  1  asynchronous active-low reset
btn  in  4  raw digit keys, active-high; key k means code k
btn_ok  in  1  raw confirm key, active-high
btn_cancel  in  1  raw cancel key, active-high
code  out  2  selected code, drives register code input
enL  out  1  one-cycle row-load strobe
enC  out  1  one-cycle column-load strobe
clr_sel  out  1  one-cycle clear strobe to registers (active-high)
sel_valid  out  1  one-cycle "selection confirmed" strobe to downstream dispense logic
busy  out  1  high in S_COLUNA, S_CONFIRMA, S_FIM
state_dbg  out  2  current state encoding

Behaviour:
- Reset (clr_n=0, async): state S_LINHA; code=0; enL/enC/clr_sel/sel_valid=0; debounced levels=0; timer=0. Reset mid-selection aborts immediately; no clr_sel is emitted.
- Input path per key: 2-FF synchronizer, then debouncer. The debounced level toggles after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
- Event = debounced rising edge, one cycle wide. Release generates no event.
- Same-cycle priority: cancel > timeout > ok > digit. If several digit events occur together, the lowest index wins.
- All strobes are registered: asserted the cycle after the event cycle, for exactly one cycle. code updates on the same edge as its enL/enC strobe and holds until the next load.
- States: S_LINHA=00, S_COLUNA=01, S_CONFIRMA=10, S_FIM=11.
- S_LINHA:
  - digit k -> code=k, enL, go S_COLUNA.
  - cancel -> clr_sel, stay.
  - ok -> ignored.
- S_COLUNA:
  - digit k -> code=k, enC, go S_CONFIRMA.
  - cancel or timeout -> clr_sel, go S_LINHA.
  - ok -> ignored.
- S_CONFIRMA:
  - ok -> sel_valid, go S_FIM.
  - digit k -> code=k, enC (column replaced), stay.
  - cancel or timeout -> clr_sel, go S_LINHA.
- S_FIM: lasts one cycle, then S_LINHA. All events in this cycle are discarded.
- Timer:
  - Cleared on entry to S_COLUNA/S_CONFIRMA and on every accepted event; counts otherwise.
  - Timeout fires when timer reaches TIMEOUT_CYCLES-1, and only in S_COLUNA/S_CONFIRMA.
  - Width is clog2(TIMEOUT_CYCLES); saturates and never wraps.
- enL and enC are never high together. At most one strobe is high in any cycle.
- A key held down produces exactly one event.

Decomposition:
- Package sel_pkg: state encodings S_LINHA..S_FIM, CODE_W=2, NUM_DIGITS=4.
- Sub-module debouncer (1 bit, parameter DEBOUNCE_CYCLES): synchronizer, counter, stable level, rise pulse. Instantiated six times.

Test Plan (all with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20):
- Clean selection: press btn[2], release, press btn[1], then btn_ok -> enL with code=2; enC with code=1; sel_valid one cycle; busy falls; state returns 00.
- Bounce: btn[3] toggling every 2 cycles for 10 cycles, then stable high -> no strobes during the bounce; exactly one enL with code=3 after the level is stable for 4 cycles.
- Timeout: row 0 entered, no further keys for 20 cycles -> clr_sel pulse; state 00; a later btn_ok is ignored (no sel_valid).
- Cancel priority: in S_CONFIRMA, btn_cancel and btn_ok debounced rising in the same cycle -> clr_sel only, no sel_valid, state 00.
- Column replace and simultaneous digits: in S_CONFIRMA press btn[1] and btn[3] together -> one enC with code=1; state stays 10; the timer restarts.
- Async reset mid-operation: clr_n low in S_CONFIRMA -> all outputs 0 immediately with no clr_sel; after release, a held btn[0] produces no event until it is released and pressed again.
